// File: rtl/bus_pkg.sv
// Shared types and elaboration-time helpers for the round-robin bus interconnect.
// Holds no logic; latency and backpressure are defined by the modules that use it.
package bus_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Index width that stays at least one bit, so a 1-entry range still has a port
  function automatic int idx_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  // Low bit of lane `idx` in a flattened vector of `w`-bit lanes
  function automatic int lane_lo(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/bus_rr_arbiter.sv
// Rotating-priority pick of the first unmasked requester at or after ptr.
// Purely combinational (0 cycles); it only reports a winner and applies no backpressure.
module bus_rr_arbiter
  import bus_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]          req,
  input  logic [N-1:0]          mask,
  input  logic [idx_w(N)-1:0]   ptr,
  output logic [idx_w(N)-1:0]   win_idx,
  output logic                  win_vld
);

  localparam int IDX_W = idx_w(N);

  // Walk offsets from farthest to nearest so the nearest eligible requester wins
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int off = N - 1; off >= 0; off--) begin
      if (req[(int'(ptr) + off) % N] && !mask[(int'(ptr) + off) % N]) begin
        win_vld = 1'b1;
        win_idx = IDX_W'((int'(ptr) + off) % N);
      end
    end
  end

endmodule

// File: rtl/bus_interconnect_rr.sv
// NUM_M x NUM_S round-robin interconnect: grant rises 1 cycle after request, routing is combinational.
// A stalled slave (s_slave_ready=0) is tolerated for TIMEOUT cycles, then the master is aborted with m_error.
module bus_interconnect_rr
  import bus_pkg::*;
#(
  parameter int NUM_M   = 2,
  parameter int NUM_S   = 3,
  parameter int LANE_W  = 1,
  parameter int TIMEOUT = 1023
) (
  input  logic                              sys_clk,
  input  logic                              sys_rst,
  input  logic [NUM_M-1:0]                  m_request,
  input  logic [NUM_M*idx_w(NUM_S)-1:0]     m_slave_sel,
  output logic [NUM_M-1:0]                  m_grant,
  output logic [NUM_M-1:0]                  m_error,
  input  logic [NUM_M-1:0]                  m_valid,
  input  logic [NUM_M*LANE_W-1:0]           m_tx_address,
  input  logic [NUM_M*LANE_W-1:0]           m_tx_data,
  input  logic [NUM_M-1:0]                  m_write_en,
  input  logic [NUM_M-1:0]                  m_read_en,
  output logic [NUM_M*LANE_W-1:0]           m_rx_data,
  output logic [NUM_M-1:0]                  m_slave_ready,
  output logic [NUM_S-1:0]                  s_valid,
  output logic [NUM_S*LANE_W-1:0]           s_rx_address,
  output logic [NUM_S*LANE_W-1:0]           s_rx_data,
  output logic [NUM_S-1:0]                  s_write_en,
  output logic [NUM_S-1:0]                  s_read_en,
  input  logic [NUM_S*LANE_W-1:0]           s_tx_data,
  input  logic [NUM_S-1:0]                  s_slave_ready
);

  localparam int SEL_W  = idx_w(NUM_S);
  localparam int MIDX_W = idx_w(NUM_M);
  localparam int CNT_W  = idx_w(TIMEOUT + 1);

  state_t              state, state_n;
  logic [MIDX_W-1:0]   gnt_idx, gnt_idx_n;
  logic [MIDX_W-1:0]   ptr, ptr_n;
  logic [SEL_W-1:0]    sel_idx, sel_idx_n;
  logic [NUM_M-1:0]    mask, mask_n;
  logic [NUM_M-1:0]    err_q, err_n;
  logic [CNT_W-1:0]    cnt, cnt_n;

  logic [MIDX_W-1:0]   win_idx;
  logic                win_vld;
  logic [SEL_W-1:0]    win_sel;
  logic                win_illegal;
  logic                g_req, g_valid, sel_ready;
  logic                stall, to_hit;

  function automatic logic [MIDX_W-1:0] next_idx(input logic [MIDX_W-1:0] i);
    return (int'(i) == NUM_M - 1) ? '0 : i + 1'b1;
  endfunction

  bus_rr_arbiter #(.N(NUM_M)) u_arb (
    .req     (m_request),
    .mask    (mask),
    .ptr     (ptr),
    .win_idx (win_idx),
    .win_vld (win_vld)
  );

  // Decode the winner's target and the granted pair's handshake bits
  always_comb begin
    win_sel   = '0;
    g_req     = 1'b0;
    g_valid   = 1'b0;
    sel_ready = 1'b0;
    for (int m = 0; m < NUM_M; m++) begin
      if (win_idx == MIDX_W'(m)) win_sel = m_slave_sel[m*SEL_W +: SEL_W];
      if (gnt_idx == MIDX_W'(m)) begin
        g_req   = m_request[m];
        g_valid = m_valid[m];
      end
    end
    for (int s = 0; s < NUM_S; s++) begin
      if (sel_idx == SEL_W'(s)) sel_ready = s_slave_ready[s];
    end
  end

  assign win_illegal = (int'(win_sel) >= NUM_S);
  assign stall       = (state == BUSY) && g_valid && !sel_ready;
  assign to_hit      = stall && (cnt == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_n   = state;
    gnt_idx_n = gnt_idx;
    sel_idx_n = sel_idx;
    ptr_n     = ptr;
    mask_n    = mask & m_request;
    cnt_n     = cnt;
    err_n     = '0;
    case (state)
      IDLE: begin
        if (win_vld) begin
          if (win_illegal) begin
            err_n[win_idx]  = 1'b1;
            mask_n[win_idx] = 1'b1;
            ptr_n           = next_idx(win_idx);
          end else begin
            gnt_idx_n = win_idx;
            sel_idx_n = win_sel;
            cnt_n     = '0;
            state_n   = BUSY;
          end
        end
      end
      BUSY: begin
        // Timeout outranks a simultaneous release so the abort is always recorded
        if (to_hit) begin
          state_n         = IDLE;
          mask_n[gnt_idx] = 1'b1;
          ptr_n           = next_idx(gnt_idx);
          cnt_n           = '0;
        end else if (!g_req) begin
          state_n = IDLE;
          ptr_n   = next_idx(gnt_idx);
          cnt_n   = '0;
        end else if (stall) begin
          cnt_n = cnt + 1'b1;
        end else begin
          cnt_n = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state   <= IDLE;
      gnt_idx <= '0;
      sel_idx <= '0;
      ptr     <= '0;
      mask    <= '0;
      err_q   <= '0;
      cnt     <= '0;
    end else begin
      state   <= state_n;
      gnt_idx <= gnt_idx_n;
      sel_idx <= sel_idx_n;
      ptr     <= ptr_n;
      mask    <= mask_n;
      err_q   <= err_n;
      cnt     <= cnt_n;
    end
  end

  // Outputs decode only registered indices, so reset removes routing at once
  always_comb begin
    m_grant       = '0;
    m_error       = err_q;
    m_rx_data     = '0;
    m_slave_ready = '0;
    s_valid       = '0;
    s_rx_address  = '0;
    s_rx_data     = '0;
    s_write_en    = '0;
    s_read_en     = '0;
    if (state == BUSY) begin
      for (int m = 0; m < NUM_M; m++) begin
        if (gnt_idx == MIDX_W'(m)) begin
          m_grant[m] = 1'b1;
          m_error[m] = m_error[m] | to_hit;
          for (int s = 0; s < NUM_S; s++) begin
            if (sel_idx == SEL_W'(s)) begin
              s_valid[s]    = m_valid[m];
              s_write_en[s] = m_write_en[m];
              s_read_en[s]  = m_read_en[m];
              s_rx_address[lane_lo(s, LANE_W) +: LANE_W] = m_tx_address[lane_lo(m, LANE_W) +: LANE_W];
              s_rx_data[lane_lo(s, LANE_W) +: LANE_W]    = m_tx_data[lane_lo(m, LANE_W) +: LANE_W];
              m_rx_data[lane_lo(m, LANE_W) +: LANE_W]    = s_tx_data[lane_lo(s, LANE_W) +: LANE_W];
              m_slave_ready[m] = s_slave_ready[s];
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_bus_interconnect_rr.sv
// Randomised rounds of requests checked against a round-robin service-order model and per-cycle routing rules.
module tb_bus_interconnect_rr;

  localparam int NM = 4;
  localparam int NS = 3;
  localparam int LW = 8;
  localparam int TO = 8;
  localparam int SW = 2;
  localparam int K_GNT = 0;
  localparam int K_ERR = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NM-1:0]    m_request = '0;
  logic [NM*SW-1:0] m_slave_sel = '0;
  logic [NM-1:0]    m_grant, m_error, m_slave_ready;
  logic [NM-1:0]    m_valid = '0, m_write_en = '0, m_read_en = '0;
  logic [NM*LW-1:0] m_tx_address = '0, m_tx_data = '0;
  logic [NM*LW-1:0] m_rx_data;
  logic [NS-1:0]    s_valid, s_write_en, s_read_en;
  logic [NS*LW-1:0] s_rx_address, s_rx_data;
  logic [NS*LW-1:0] s_tx_data = '0;
  logic [NS-1:0]    s_slave_ready = '0;

  bus_interconnect_rr #(.NUM_M(NM), .NUM_S(NS), .LANE_W(LW), .TIMEOUT(TO)) dut (
    .sys_clk(clk), .sys_rst(rst_n),
    .m_request(m_request), .m_slave_sel(m_slave_sel),
    .m_grant(m_grant), .m_error(m_error),
    .m_valid(m_valid), .m_tx_address(m_tx_address), .m_tx_data(m_tx_data),
    .m_write_en(m_write_en), .m_read_en(m_read_en),
    .m_rx_data(m_rx_data), .m_slave_ready(m_slave_ready),
    .s_valid(s_valid), .s_rx_address(s_rx_address), .s_rx_data(s_rx_data),
    .s_write_en(s_write_en), .s_read_en(s_read_en),
    .s_tx_data(s_tx_data), .s_slave_ready(s_slave_ready)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int kind;
    int m;
    int sel;
  } ev_t;
  ev_t exp_q[$];

  // Bus noise: every lane randomised each cycle; hold/force masks pin the signals a scenario needs
  logic [NM-1:0] hold_mask = '0, hold_val = '0;
  logic [NS-1:0] force_stall = '0;
  initial begin
    forever begin
      @(posedge clk);
      #2;
      m_valid       = (NM'($urandom) & ~hold_mask) | hold_val;
      m_tx_address  = $urandom;
      m_tx_data     = $urandom;
      m_write_en    = NM'($urandom);
      m_read_en     = NM'($urandom);
      s_tx_data     = (NS*LW)'($urandom);
      s_slave_ready = NS'($urandom) & ~force_stall;
    end
  end

  // Monitor: consumes expected grant/error events and checks routing every cycle
  int cur = -1;
  int cur_sel = 0;
  logic [NM-1:0] prev_gnt = '0;
  always @(negedge clk) begin
    ev_t e;
    logic [NS-1:0] ev_v, ev_we, ev_re;
    logic [NS*LW-1:0] ea, ed;
    logic [NM*LW-1:0] er;
    logic [NM-1:0] ery, eg;
    if (!rst_n) begin
      exp_q.delete();
      cur = -1;
      prev_gnt = '0;
    end else begin
      if (m_grant != '0 && m_grant != prev_gnt) begin
        if (exp_q.size() == 0) begin
          check("grant_unexpected", m_grant, 0);
          cur = -1;
        end else begin
          e = exp_q.pop_front();
          check("grant_event", {e.kind == K_GNT, m_grant}, {1'b1, NM'(1 << e.m)});
          cur = e.m;
          cur_sel = e.sel;
        end
      end else if (m_grant == '0) begin
        cur = -1;
      end
      if (m_error != '0) begin
        if (exp_q.size() == 0) begin
          check("error_unexpected", m_error, 0);
        end else begin
          e = exp_q.pop_front();
          check("error_event", {e.kind == K_ERR, m_error}, {1'b1, NM'(1 << e.m)});
        end
      end
      ev_v = '0; ev_we = '0; ev_re = '0; ea = '0; ed = '0; er = '0; ery = '0; eg = '0;
      if (cur >= 0) begin
        eg[cur]    = 1'b1;
        ev_v[cur_sel]  = m_valid[cur];
        ev_we[cur_sel] = m_write_en[cur];
        ev_re[cur_sel] = m_read_en[cur];
        ea[cur_sel*LW +: LW] = m_tx_address[cur*LW +: LW];
        ed[cur_sel*LW +: LW] = m_tx_data[cur*LW +: LW];
        er[cur*LW +: LW]     = s_tx_data[cur_sel*LW +: LW];
        ery[cur]             = s_slave_ready[cur_sel];
      end
      check("routing",
            {m_grant, s_valid, s_write_en, s_read_en, s_rx_address, s_rx_data, m_rx_data, m_slave_ready},
            {eg, ev_v, ev_we, ev_re, ea, ed, er, ery});
      prev_gnt = m_grant;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ev(input int kind, input int m, output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      n++;
      if ((kind == K_GNT) ? m_grant[m] : m_error[m]) return;
    end
    n = -1;
  endtask

  // Reference: a set of simultaneous requesters is served once each, in rotation order from ptr_m
  int ptr_m = 0;
  bit abort = 1'b0;
  int r_in[NM];
  int r_mode[NM];   // 0 normal, 1 illegal slave, 2 slave never ready
  int r_sel[NM];

  task automatic run_round();
    int ord[$];
    int n, m, len;
    for (int off = 0; off < NM; off++) begin
      m = (ptr_m + off) % NM;
      if (r_in[m] != 0) ord.push_back(m);
    end
    if (ord.size() == 0) return;
    foreach (ord[k]) begin
      m = ord[k];
      if (r_mode[m] == 1) exp_q.push_back('{K_ERR, m, 0});
      else begin
        exp_q.push_back('{K_GNT, m, r_sel[m]});
        if (r_mode[m] == 2) exp_q.push_back('{K_ERR, m, 0});
      end
    end
    ptr_m = (ord[ord.size()-1] + 1) % NM;
    for (int i = 0; i < NM; i++) begin
      m_slave_sel[i*SW +: SW] = SW'(r_sel[i]);
      m_request[i] = (r_in[i] != 0);
    end
    foreach (ord[k]) begin
      m = ord[k];
      if (r_mode[m] == 1) begin
        wait_ev(K_ERR, m, n);
        check("illegal_latency", n, 1);
        if (n < 0) begin abort = 1'b1; return; end
        check("illegal_no_grant", m_grant, 0);
        m_request[m] = 1'b0;
      end else begin
        wait_ev(K_GNT, m, n);
        check("grant_latency", n, 1);
        if (n < 0) begin abort = 1'b1; return; end
        if (r_mode[m] == 2) begin
          hold_mask[m] = 1'b1;
          hold_val[m]  = 1'b1;
          force_stall[r_sel[m]] = 1'b1;
          wait_ev(K_ERR, m, n);
          check("timeout_latency", n, TO - 1);
          if (n < 0) begin abort = 1'b1; return; end
          step();
          check("timeout_grant_drop", m_grant, 0);
          check("timeout_svalid", s_valid, 0);
          hold_mask[m] = 1'b0;
          hold_val[m]  = 1'b0;
          force_stall  = '0;
          m_request[m] = 1'b0;
        end else begin
          len = $urandom_range(1, 6);
          repeat (len) step();
          m_request[m] = 1'b0;
          step();
          check("release_grant_drop", m_grant, 0);
        end
      end
    end
    repeat (3) step();
    check("queue_drained", exp_q.size(), 0);
  endtask

  task automatic set_round(input int m, input int in_r, input int mode, input int sel);
    r_in[m] = in_r;
    r_mode[m] = mode;
    r_sel[m] = sel;
  endtask

  initial begin
    int n;
    for (int i = 0; i < NM; i++) set_round(i, 0, 0, 0);
    m_request = '1;
    m_slave_sel = '1;
    repeat (3) step();
    check("reset_outputs",
          {m_grant, m_error, m_rx_data, m_slave_ready, s_valid, s_rx_address, s_rx_data, s_write_en, s_read_en}, 0);
    m_request = '0;
    step();
    rst_n = 1'b1;
    step();

    // All four together: served 0,1,2,3
    set_round(0, 1, 0, 2); set_round(1, 1, 0, 1); set_round(2, 1, 0, 0); set_round(3, 1, 0, 2);
    run_round();
    // Pointer wrapped: 0 again, then 1
    set_round(2, 0, 0, 0); set_round(3, 0, 0, 0);
    if (!abort) run_round();
    // From ptr 2: 3 normal, 0 times out on slave 1, 1 hits an illegal slave
    set_round(0, 1, 2, 1); set_round(1, 1, 1, 3); set_round(3, 1, 0, 2);
    if (!abort) run_round();

    for (int r = 0; r < 40 && !abort; r++) begin
      int any;
      any = 0;
      for (int i = 0; i < NM; i++) begin
        int x;
        x = $urandom_range(0, 5);
        set_round(i, $urandom_range(0, 1), (x == 0) ? 1 : (x == 1) ? 2 : 0,
                  (x == 0) ? 3 : $urandom_range(0, 2));
        any += r_in[i];
      end
      if (any == 0) r_in[$urandom_range(0, NM - 1)] = 1;
      run_round();
    end

    // Reset while master 2 owns slave 1
    if (!abort) begin
      exp_q.push_back('{K_GNT, 2, 1});
      m_slave_sel[2*SW +: SW] = 2'd1;
      m_request[2] = 1'b1;
      hold_mask[2] = 1'b1;
      hold_val[2]  = 1'b1;
      wait_ev(K_GNT, 2, n);
      check("pre_reset_grant", n, 1);
      step();
      check("pre_reset_svalid", s_valid, 3'b010);
      #3;
      rst_n = 1'b0;
      #1;
      check("reset_grant", m_grant, 0);
      check("reset_svalid", s_valid, 0);
      check("reset_swe", s_write_en, 0);
      m_request = '0;
      hold_mask = '0;
      hold_val  = '0;
      repeat (3) step();
      rst_n = 1'b1;
      ptr_m = 0;
      step();
      for (int i = 0; i < NM; i++) set_round(i, 0, 0, 0);
      set_round(3, 1, 0, 0); set_round(0, 1, 0, 2);
      run_round();
    end

    if (abort) begin
      failures++;
      $display("FAIL aborted_run actual=%0d expected=0", abort);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
